// File: rtl/pipelined_cla_adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// NZCV flag bit positions, the default datapath width and the overflow rule.
package pipelined_cla_adder_pkg;

    localparam int DEFAULT_N = 32;

    // Bit positions inside a packed NZCV nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] nzcv_t;

    // Two's-complement overflow: operands agree in sign, result disagrees
    function automatic logic signed_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_segment.sv
// One pipeline segment of the adder: a purely combinational W-bit adder made of
// BLOCK-wide lookahead groups, with a second lookahead level across the groups.
module carry_lookahead_adder_block
    import pipelined_cla_adder_pkg::*;
#(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] i_a,
    input  logic [BLOCK-1:0] i_b,
    input  logic             i_cin,
    output logic [BLOCK-1:0] o_s,
    output logic             o_gg,
    output logic             o_gp
);
    logic [BLOCK-1:0] w_p;
    logic [BLOCK-1:0] w_g;
    logic [BLOCK:0]   w_c;
    logic             w_gg;
    logic             w_gp;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    // Internal carries plus group generate/propagate (the latter independent of i_cin)
    always_comb begin
        w_c[0] = i_cin;
        w_gg   = 1'b0;
        w_gp   = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
            w_gg     = w_g[i] | (w_p[i] & w_gg);
            w_gp     = w_gp & w_p[i];
        end
    end

    assign o_s  = w_p ^ w_c[BLOCK-1:0];
    assign o_gg = w_gg;
    assign o_gp = w_gp;
endmodule

module cla_segment
    import pipelined_cla_adder_pkg::*;
#(
    parameter int W     = 16,
    parameter int BLOCK = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_s,
    output logic         o_cout
);
    localparam int GROUPS = W / BLOCK;

    logic [GROUPS-1:0] w_grp_g;
    logic [GROUPS-1:0] w_grp_p;
    logic [GROUPS:0]   w_grp_c;

    genvar gi;
    generate
        for (gi = 0; gi < GROUPS; gi++) begin : g_grp
            carry_lookahead_adder_block #(.BLOCK(BLOCK)) u_blk (
                .i_a   (i_a[gi*BLOCK +: BLOCK]),
                .i_b   (i_b[gi*BLOCK +: BLOCK]),
                .i_cin (w_grp_c[gi]),
                .o_s   (o_s[gi*BLOCK +: BLOCK]),
                .o_gg  (w_grp_g[gi]),
                .o_gp  (w_grp_p[gi])
            );
        end
    endgenerate

    // Group carries from group generate/propagate, so no carry ripples through a block
    always_comb begin
        w_grp_c[0] = i_cin;
        for (int k = 0; k < GROUPS; k++) begin
            w_grp_c[k+1] = w_grp_g[k] | (w_grp_p[k] & w_grp_c[k]);
        end
    end

    assign o_cout = w_grp_c[GROUPS];
endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor with NZCV flags. Each stage resolves one W-bit
// segment; operands, partial sums, the carry and a running zero flag travel
// together so the full result emerges from the last stage register.
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int STAGES = 2,
    parameter int BLOCK  = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         flag_n,
    output logic         flag_z,
    output logic         flag_c,
    output logic         flag_v
);
    localparam int W = N / STAGES;
    localparam int L = STAGES - 1;
    localparam logic [N-1:0] SEG_MASK = N'({W{1'b1}});

    logic [N-1:0]      w_b_eff;
    logic [STAGES:0]   w_adv;
    logic [STAGES-1:0] w_src_valid, w_src_c, w_src_z, w_nxt_c, w_nxt_z;
    logic [N-1:0]      w_src_a [STAGES];
    logic [N-1:0]      w_src_b [STAGES];
    logic [N-1:0]      w_src_s [STAGES];
    logic [N-1:0]      w_nxt_s [STAGES];
    logic [W-1:0]      w_seg_s [STAGES];
    nzcv_t             w_flags;

    logic [STAGES-1:0] r_valid, r_c, r_z;
    logic [N-1:0]      r_a [STAGES];
    logic [N-1:0]      r_b [STAGES];
    logic [N-1:0]      r_s [STAGES];

    assign w_b_eff = sub ? ~b : b;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_src_valid[gi] = in_valid;
                assign w_src_a[gi]     = a;
                assign w_src_b[gi]     = w_b_eff;
                assign w_src_s[gi]     = '0;
                assign w_src_c[gi]     = cin;
                assign w_src_z[gi]     = 1'b1;
            end else begin : g_body
                assign w_src_valid[gi] = r_valid[gi-1];
                assign w_src_a[gi]     = r_a[gi-1];
                assign w_src_b[gi]     = r_b[gi-1];
                assign w_src_s[gi]     = r_s[gi-1];
                assign w_src_c[gi]     = r_c[gi-1];
                assign w_src_z[gi]     = r_z[gi-1];
            end

            cla_segment #(.W(W), .BLOCK(BLOCK)) u_seg (
                .i_a    (w_src_a[gi][gi*W +: W]),
                .i_b    (w_src_b[gi][gi*W +: W]),
                .i_cin  (w_src_c[gi]),
                .o_s    (w_seg_s[gi]),
                .o_cout (w_nxt_c[gi])
            );

            // Splice this segment's sum into the word carried forward
            assign w_nxt_s[gi] = (w_src_s[gi] & ~(SEG_MASK << (gi*W))) | (N'(w_seg_s[gi]) << (gi*W));
            assign w_nxt_z[gi] = w_src_z[gi] & (w_seg_s[gi] == '0);
        end
    endgenerate

    // Backpressure chain: a stage moves when it is empty or its successor moves
    always_comb begin
        w_adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_adv[k] = ~r_valid[k] | w_adv[k+1];
        end
    end

    assign in_ready = w_adv[0];

    // Stage registers: valid follows the handshake, data only loads for a real operation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_c     <= '0;
            r_z     <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= w_src_valid[k];
                    if (w_src_valid[k]) begin
                        r_a[k] <= w_src_a[k];
                        r_b[k] <= w_src_b[k];
                        r_s[k] <= w_nxt_s[k];
                        r_c[k] <= w_nxt_c[k];
                        r_z[k] <= w_nxt_z[k];
                    end
                end
            end
        end
    end

    // Flags decoded straight from the last stage register, no extra cycle
    always_comb begin
        w_flags         = '0;
        w_flags[FLAG_N] = r_s[L][N-1];
        w_flags[FLAG_Z] = r_z[L];
        w_flags[FLAG_C] = r_c[L];
        w_flags[FLAG_V] = signed_overflow(r_a[L][N-1], r_b[L][N-1], r_s[L][N-1]);
    end

    assign out_valid = r_valid[L];
    assign s         = r_s[L];
    assign flag_n    = w_flags[FLAG_N];
    assign flag_z    = w_flags[FLAG_Z];
    assign flag_c    = w_flags[FLAG_C];
    assign flag_v    = w_flags[FLAG_V];
endmodule
